// File: rtl/ntt_tf_pkg.sv
// Shared constants and types for the NTT twiddle-factor address schedule.
// Holds the per-stage ROM base/word-count table and the sequencer state encoding.
package ntt_tf_pkg;

   localparam int TF_ADDR_W = 6;
   localparam int TF_STAGES = 5;

   localparam logic [5:0] STAGE_BASE [TF_STAGES] =
      '{6'd0, 6'd2, 6'd6, 6'd10, 6'd26};
   localparam logic [4:0] STAGE_WORDS [TF_STAGES] =
      '{5'd2, 5'd4, 5'd4, 5'd16, 5'd16};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } tf_state_e;

   function automatic logic [5:0] stage_base(input logic [2:0] s);
      logic [5:0] r;
      r = '0;
      case (s)
         3'd0: r = STAGE_BASE[0];
         3'd1: r = STAGE_BASE[1];
         3'd2: r = STAGE_BASE[2];
         3'd3: r = STAGE_BASE[3];
         3'd4: r = STAGE_BASE[4];
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [4:0] stage_words(input logic [2:0] s);
      logic [4:0] r;
      r = 5'd1;
      case (s)
         3'd0: r = STAGE_WORDS[0];
         3'd1: r = STAGE_WORDS[1];
         3'd2: r = STAGE_WORDS[2];
         3'd3: r = STAGE_WORDS[3];
         3'd4: r = STAGE_WORDS[4];
         default: r = 5'd1;
      endcase
      return r;
   endfunction

   // Word counts are powers of two, so hold length is a shift, not a divide.
   function automatic logic [2:0] stage_wlog(input logic [2:0] s);
      logic [2:0] r;
      r = '0;
      case (s)
         3'd0: r = 3'($clog2(STAGE_WORDS[0]));
         3'd1: r = 3'($clog2(STAGE_WORDS[1]));
         3'd2: r = 3'($clog2(STAGE_WORDS[2]));
         3'd3: r = 3'($clog2(STAGE_WORDS[3]));
         3'd4: r = 3'($clog2(STAGE_WORDS[4]));
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/tf_addr_gen_if.sv
// Control/ROM-side bundle of the twiddle address generator.
// master drives start/stall, slave (the generator) drives everything else.
interface tf_addr_gen_if
   import ntt_tf_pkg::*;
#(
   parameter int ADDR_W = TF_ADDR_W
);

   logic              start;
   logic              stall;
   logic [ADDR_W-1:0] A;
   logic              IREN;
   logic [2:0]        stage;
   logic              tf_valid;
   logic              busy;
   logic              done;

   modport master (
      output start, stall,
      input  A, IREN, stage, tf_valid, busy, done
   );

   modport slave (
      input  start, stall,
      output A, IREN, stage, tf_valid, busy, done
   );

endinterface

// File: rtl/tf_addr_gen.sv
// Twiddle ROM address sequencer for the 512-point mixed-radix NTT.
// Walks the stage/word/hold schedule and flags the ROM's registered output.
module tf_addr_gen
   import ntt_tf_pkg::*;
#(
   parameter int ADDR_W        = TF_ADDR_W,
   parameter int CYC_PER_STAGE = 64,
   parameter int NUM_STAGES    = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   tf_addr_gen_if.slave bus
);

   localparam int HW = $clog2(CYC_PER_STAGE);

   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_RUN   = ST_RUN;
   localparam logic [1:0] S_FLUSH = ST_FLUSH;

   logic [1:0]    state;
   logic [2:0]    stg;
   logic [3:0]    word;
   logic [HW-1:0] hold;
   logic          tfv;

   logic          issue;
   logic [HW-1:0] hold_last;
   logic          word_last;
   logic          stage_last;
   logic [5:0]    base;

   assign issue      = (state == S_RUN) && !bus.stall;
   assign base       = stage_base(stg);
   assign hold_last  = HW'((CYC_PER_STAGE >> stage_wlog(stg)) - 1);
   assign word_last  = ({1'b0, word} == (stage_words(stg) - 5'd1));
   assign stage_last = (stg == 3'(NUM_STAGES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         stg   <= '0;
         word  <= '0;
         hold  <= '0;
         tfv   <= 1'b0;
      end else begin
         tfv <= issue;
         unique case (1'b1)
            (state == S_IDLE): begin
               if (bus.start) begin
                  state <= S_RUN;
                  stg   <= '0;
                  word  <= '0;
                  hold  <= '0;
               end
            end
            (state == S_RUN): begin
               if (issue) begin
                  if (hold != hold_last) begin
                     hold <= hold + 1'b1;
                  end else begin
                     hold <= '0;
                     if (!word_last) begin
                        word <= word + 1'b1;
                     end else begin
                        word <= '0;
                        if (!stage_last) begin
                           stg <= stg + 1'b1;
                        end else begin
                           stg   <= '0;
                           state <= S_FLUSH;
                        end
                     end
                  end
               end
            end
            default: begin
               // FLUSH, or an unreachable encoding: drop back to idle
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.A        = (state == S_RUN) ?
                         (ADDR_W'(base) + ADDR_W'(word)) : '0;
   assign bus.IREN     = issue;
   assign bus.stage    = stg;
   assign bus.tf_valid = tfv;
   assign bus.busy     = (state != S_IDLE);
   assign bus.done     = (state == S_FLUSH);

endmodule
